// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the memory port arbiter.
// Holds the owner FSM state, read-return owner tag and bus widths.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic {
        S_CPU = 1'b0,
        S_DBG = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DBG  = 2'd2
    } rd_own_t;

endpackage

// File: rtl/mem_arbiter.sv
// Shares one synchronous memory port between the 6502 core and a debug
// port. Ports: ph2/resetb clock+reset, cpu_* core side (cpu_rdy stalls
// the core), dbg_* debug side (dbg_gnt/dbg_rvalid), mem_* memory side.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int MAX_DBG_BURST = 4
) (
    input  logic              ph2,
    input  logic              resetb,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic              cpu_lock,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_rdy,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dbg_req,
    input  logic              dbg_we,
    input  logic              dbg_last,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic [DATA_W-1:0] dbg_wdata,
    output logic              dbg_gnt,
    output logic              dbg_rvalid,
    output logic [DATA_W-1:0] dbg_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int CW = $clog2(MAX_DBG_BURST) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MAX_DBG_BURST - 1);

    arb_state_t        state_q, state_d;
    logic [CW-1:0]     burst_cnt_q, burst_cnt_d;
    rd_own_t           rd_own_q, rd_own_d;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] dbg_rdata_q;
    logic              handover;
    logic              dbg_xfer;
    logic              dbg_done;

    // Only hand over when the CPU is not writing and not mid-RMW.
    assign handover = dbg_req & ~cpu_lock & (~cpu_req | ~cpu_we);
    assign dbg_xfer = (state_q == S_DBG) & dbg_req;
    assign dbg_done = dbg_xfer & (dbg_last | (burst_cnt_q == CNT_LAST));

    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        rd_own_d    = OWN_NONE;
        unique case (state_q)
            S_CPU: begin
                burst_cnt_d = '0;
                if (handover) state_d = S_DBG;
                if (cpu_req & ~cpu_we) rd_own_d = OWN_CPU;
            end
            S_DBG: begin
                if (dbg_xfer & ~dbg_we) rd_own_d = OWN_DBG;
                // Clearing on exit keeps the count zero for the whole
                // CPU slot, so the next burst starts fresh.
                if (!dbg_req || dbg_done) begin
                    state_d     = S_CPU;
                    burst_cnt_d = '0;
                end else begin
                    burst_cnt_d = burst_cnt_q + CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge ph2 or negedge resetb) begin
        if (!resetb) begin
            state_q     <= S_CPU;
            burst_cnt_q <= '0;
            rd_own_q    <= OWN_NONE;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            rd_own_q    <= rd_own_d;
            cpu_rdata_q <= cpu_rdata;
            dbg_rdata_q <= dbg_rdata;
        end
    end

    // Memory mux follows the current owner combinationally.
    always_comb begin
        if (state_q == S_DBG) begin
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            mem_we    = resetb & dbg_req & dbg_we;
        end else begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_we    = resetb & cpu_req & cpu_we;
        end
    end

    assign cpu_rdy = (state_q == S_CPU);
    assign dbg_gnt = dbg_xfer;

    // Read data is steered by who issued the read one cycle earlier;
    // otherwise the last captured byte is held (stable while stalled).
    assign cpu_rdata  = (rd_own_q == OWN_CPU) ? mem_rdata : cpu_rdata_q;
    assign dbg_rdata  = (rd_own_q == OWN_DBG) ? mem_rdata : dbg_rdata_q;
    assign dbg_rvalid = (rd_own_q == OWN_DBG);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter with a synchronous memory model.
// Directed vectors; a negedge monitor checks read returns from queues.
module tb_mem_arbiter;

    logic        ph2 = 1'b0;
    logic        resetb;
    logic        cpu_req, cpu_we, cpu_lock;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_rdy;
    logic [7:0]  cpu_rdata;
    logic        dbg_req, dbg_we, dbg_last;
    logic [15:0] dbg_addr;
    logic [7:0]  dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [7:0]  dbg_rdata;
    logic [15:0] mem_addr;
    logic        mem_we;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata = 8'h00;

    logic [7:0] mem [0:65535];

    int ncmp = 0;
    int nbad = 0;

    logic [7:0] cpu_q[$];
    logic [7:0] dbg_q[$];
    logic       cpu_pend = 1'b0;
    logic       dbg_pend = 1'b0;
    logic       chk_hold = 1'b0;
    logic [7:0] exp_hold = 8'h00;

    always #5 ph2 = ~ph2;

    mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(8),
        .MAX_DBG_BURST(4)
    ) dut (
        .ph2       (ph2),
        .resetb    (resetb),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_lock  (cpu_lock),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdy   (cpu_rdy),
        .cpu_rdata (cpu_rdata),
        .dbg_req   (dbg_req),
        .dbg_we    (dbg_we),
        .dbg_last  (dbg_last),
        .dbg_addr  (dbg_addr),
        .dbg_wdata (dbg_wdata),
        .dbg_gnt   (dbg_gnt),
        .dbg_rvalid(dbg_rvalid),
        .dbg_rdata (dbg_rdata),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Synchronous memory: data one cycle after address.
    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
        mem[16'h0002] = 8'hFF;
        mem[16'h01DD] = 8'h6E;
        mem[16'h0400] = 8'hC3;
        mem[16'h1234] = 8'h5A;
        mem[16'hFFFC] = 8'h34;
        forever begin
            @(posedge ph2);
            if (mem_we) mem[mem_addr] <= mem_wdata;
            mem_rdata <= mem[mem_addr];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: pops expected read data whenever the DUT returns it.
    always @(negedge ph2) begin
        if (!resetb) begin
            cpu_pend = 1'b0;
            dbg_pend = 1'b0;
        end else begin
            if (cpu_pend) begin
                if (cpu_q.size() == 0)
                    chk("cpu_q_underflow", 1, 0);
                else
                    chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
            end
            if (dbg_pend || dbg_rvalid)
                chk("dbg_rvalid_lat", dbg_rvalid, dbg_pend);
            if (dbg_rvalid) begin
                if (dbg_q.size() == 0)
                    chk("dbg_q_underflow", 1, 0);
                else
                    chk("dbg_rdata", dbg_rdata, dbg_q.pop_front());
            end
            cpu_pend = cpu_req & ~cpu_we & cpu_rdy;
            dbg_pend = dbg_gnt & ~dbg_we;
        end
    end

    // Present a debug transfer and hold it until granted.
    task automatic dbg_xfer(input logic we, input logic [15:0] a,
                            input logic [7:0] d, input logic last,
                            input logic [7:0] exp_rd, output int waited);
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
        dbg_last  = last;
        waited    = 0;
        @(negedge ph2);
        while (!dbg_gnt && waited < 20) begin
            @(negedge ph2);
            waited++;
        end
        if (!dbg_gnt) begin
            chk("dbg_gnt_timeout", 0, 1);
        end else begin
            if (!we) dbg_q.push_back(exp_rd);
            chk("cpu_rdy_stall", cpu_rdy, 0);
            if (chk_hold) chk("cpu_rdata_hold", cpu_rdata, exp_hold);
        end
        @(posedge ph2);
        #1;
    endtask

    task automatic idle_cyc();
        @(posedge ph2);
        #1;
    endtask

    logic [10:0] gnt_pat;
    int w;

    initial begin
        resetb    = 1'b0;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_lock  = 1'b0;
        cpu_addr  = 16'h0300;
        cpu_wdata = 8'hEE;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_last  = 1'b0;
        dbg_addr  = 16'h0000;
        dbg_wdata = 8'h00;

        // Reset state; mem_we forced low despite a CPU write request.
        repeat (3) @(posedge ph2);
        @(negedge ph2);
        chk("rst_cpu_rdy", cpu_rdy, 1);
        chk("rst_dbg_gnt", dbg_gnt, 0);
        chk("rst_dbg_rvalid", dbg_rvalid, 0);
        chk("rst_cpu_rdata", cpu_rdata, 8'h00);
        chk("rst_dbg_rdata", dbg_rdata, 8'h00);
        chk("rst_mem_we", mem_we, 0);
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
        @(posedge ph2);
        #3 resetb = 1'b1;
        idle_cyc();

        // Stall data hold: CPU read then 2-transfer debug read burst.
        cpu_req  = 1'b1;
        cpu_addr = 16'h1234;
        cpu_q.push_back(8'h5A);
        idle_cyc();
        cpu_req  = 1'b0;
        chk_hold = 1'b1;
        exp_hold = 8'h5A;
        dbg_xfer(1'b0, 16'h01DD, 8'h00, 1'b0, 8'h6E, w);
        chk("hold_wait0", w, 1);
        dbg_xfer(1'b0, 16'h1234, 8'h00, 1'b1, 8'h5A, w);
        chk("hold_wait1", w, 0);
        chk_hold = 1'b0;
        dbg_req  = 1'b0;
        @(negedge ph2);
        chk("hold_back_rdy", cpu_rdy, 1);
        idle_cyc();

        // Debug load: A9 01 00 into 0x0000..0x0002.
        dbg_xfer(1'b1, 16'h0000, 8'hA9, 1'b0, 8'h00, w);
        chk("load_wait0", w, 1);
        dbg_xfer(1'b1, 16'h0001, 8'h01, 1'b0, 8'h00, w);
        chk("load_wait1", w, 0);
        dbg_xfer(1'b1, 16'h0002, 8'h00, 1'b1, 8'h00, w);
        chk("load_wait2", w, 0);
        dbg_req = 1'b0;
        @(negedge ph2);
        chk("load_end_rdy", cpu_rdy, 1);
        chk("load_end_gnt", dbg_gnt, 0);
        idle_cyc();
        chk("rom0", mem[16'h0000], 8'hA9);
        chk("rom1", mem[16'h0001], 8'h01);
        chk("rom2", mem[16'h0002], 8'h00);
        cpu_req  = 1'b1;
        cpu_addr = 16'h0001;
        cpu_q.push_back(8'h01);
        idle_cyc();
        cpu_req = 1'b0;
        idle_cyc();

        // Starvation guard: 4 grants, 1 CPU slot, repeat.
        gnt_pat   = 11'b01111011110;
        cpu_req   = 1'b1;
        cpu_we    = 1'b0;
        cpu_addr  = 16'hFFFC;
        dbg_req   = 1'b1;
        dbg_we    = 1'b0;
        dbg_last  = 1'b0;
        dbg_addr  = 16'h01DD;
        for (int i = 0; i < 11; i++) begin
            @(negedge ph2);
            chk($sformatf("starve_gnt%0d", i), dbg_gnt, gnt_pat[i]);
            chk($sformatf("starve_rdy%0d", i), cpu_rdy, !gnt_pat[i]);
            if (gnt_pat[i]) dbg_q.push_back(8'h6E);
            else cpu_q.push_back(8'h34);
            idle_cyc();
        end
        cpu_req = 1'b0;
        dbg_req = 1'b0;
        idle_cyc();
        idle_cyc();

        // Handover blocked by CPU write, then by cpu_lock.
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 16'h0300;
        dbg_wdata = 8'h77;
        dbg_last  = 1'b1;
        cpu_req   = 1'b1;
        cpu_we    = 1'b1;
        cpu_addr  = 16'h0200;
        cpu_wdata = 8'h11;
        for (int i = 0; i < 3; i++) begin
            @(negedge ph2);
            chk("blk_wr_gnt", dbg_gnt, 0);
            chk("blk_wr_we", mem_we, 1);
            chk("blk_wr_addr", mem_addr, 16'h0200);
            idle_cyc();
        end
        cpu_we   = 1'b0;
        cpu_lock = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cpu_q.push_back(8'h11);
            @(negedge ph2);
            chk("blk_lock_gnt", dbg_gnt, 0);
            chk("blk_lock_we", mem_we, 0);
            idle_cyc();
        end
        cpu_lock = 1'b0;
        cpu_q.push_back(8'h11);
        @(negedge ph2);
        chk("blk_rd_gnt", dbg_gnt, 0);
        idle_cyc();
        cpu_req = 1'b0;
        @(negedge ph2);
        chk("blk_after_gnt", dbg_gnt, 1);
        chk("blk_after_we", mem_we, 1);
        chk("blk_after_addr", mem_addr, 16'h0300);
        idle_cyc();
        dbg_req = 1'b0;
        @(negedge ph2);
        chk("blk_back_rdy", cpu_rdy, 1);
        idle_cyc();
        chk("blk_mem_dbg", mem[16'h0300], 8'h77);
        chk("blk_mem_cpu", mem[16'h0200], 8'h11);

        // Reset in the middle of a debug write burst.
        dbg_req   = 1'b1;
        dbg_we    = 1'b1;
        dbg_addr  = 16'h0400;
        dbg_wdata = 8'h55;
        dbg_last  = 1'b0;
        @(negedge ph2);
        idle_cyc();
        @(negedge ph2);
        chk("mid_gnt", dbg_gnt, 1);
        chk("mid_we", mem_we, 1);
        #1 resetb = 1'b0;
        #1;
        chk("mid_rst_we", mem_we, 0);
        chk("mid_rst_gnt", dbg_gnt, 0);
        chk("mid_rst_rdy", cpu_rdy, 1);
        dbg_req = 1'b0;
        @(posedge ph2);
        #3 resetb = 1'b1;
        @(negedge ph2);
        chk("post_rst_rdy", cpu_rdy, 1);
        chk("post_rst_gnt", dbg_gnt, 0);
        chk("post_rst_rvalid", dbg_rvalid, 0);
        idle_cyc();
        chk("mid_no_write", mem[16'h0400], 8'hC3);

        repeat (3) idle_cyc();
        chk("cpu_q_empty", cpu_q.size(), 0);
        chk("dbg_q_empty", dbg_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 ncmp, nbad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
